// File: rtl/iosys_pkg.sv
// Shared iosys link definitions: command codes, encoder state and the
// {code, data} pair payload carried through the encoder FIFO.
package iosys_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] CMD_RESET    = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_BUTTONS  = 8'h02;
    localparam logic [BYTE_W-1:0] CMD_DIPSW    = 8'h03;
    localparam logic [BYTE_W-1:0] CMD_COIN     = 8'h04;
    localparam logic [BYTE_W-1:0] CMD_SERVICE  = 8'h05;
    localparam logic [BYTE_W-1:0] CMD_ROM_ADDR = 8'h06;
    localparam logic [BYTE_W-1:0] CMD_ROM_DATA = 8'h07;
    localparam logic [BYTE_W-1:0] CMD_STATUS   = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_CMD  = 2'd1,
        ST_SEND_DATA = 2'd2
    } enc_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] code;
        logic [BYTE_W-1:0] data;
    } cmd_pair_t;

endpackage

// File: rtl/iosys_uart_ser.sv
// 8N1 byte serialiser with trailing idle-high gap. done pulses two cycles
// before the gap ends so a registered reload starts the next frame seamlessly.
module iosys_uart_ser #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

    logic             active_q, active_d;
    logic             in_gap_q, in_gap_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             last_d;

    always_comb begin
        active_d  = active_q;
        in_gap_d  = in_gap_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        if (load) begin
            active_d  = 1'b1;
            in_gap_d  = 1'b0;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            shift_d   = {1'b1, tx_byte};
            tx_d      = 1'b0;
        end else if (active_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_d = '0;
                if (!in_gap_q) begin
                    if (bit_cnt_q == 4'd9) begin
                        tx_d = 1'b1;
                        if (GAP_BITS == 0) active_d = 1'b0;
                        else               in_gap_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b1, shift_q[8:1]};
                    end
                end else if (gap_cnt_q == GAP_LAST) begin
                    active_d = 1'b0;
                    in_gap_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end

        // Flag the second-to-last cycle of the last bit-time of the frame+gap.
        last_d = (GAP_BITS == 0) ? (!in_gap_d && bit_cnt_d == 4'd9)
                                 : (in_gap_d && gap_cnt_d == GAP_LAST);
        done_d = active_d && last_d && (clk_cnt_d == CNT_PRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            in_gap_q  <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shift_q   <= '1;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            in_gap_q  <= in_gap_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign tx   = tx_q;
    assign done = done_q;

endmodule

// File: rtl/iosys_cmd_encoder.sv
// Host-side iosys command link initiator: queues {cmd, data} pairs and sends
// each as two back-to-back 8N1 bytes, command first.
module iosys_cmd_encoder
    import iosys_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  cmd_data,
    input  logic        flush,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] pairs_sent
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    cmd_pair_t           mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    enc_state_e          state_q, state_d;
    logic                ser_load_q, ser_load_d;
    logic [BYTE_W-1:0]   ser_byte_q, ser_byte_d;
    logic [BYTE_W-1:0]   data_hold_q, data_hold_d;
    logic [15:0]         pairs_sent_q, pairs_sent_d;
    logic                busy_q, busy_d;
    logic                full_c, empty_c, push_c, pop_c, ser_done;

    assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_c   = (count_q == '0);
    assign cmd_ready = !full_c && !flush;
    assign push_c    = cmd_valid && cmd_ready;
    assign pop_c     = (state_q == ST_IDLE) && !empty_c && !flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        state_d      = state_q;
        ser_load_d   = 1'b0;
        ser_byte_d   = ser_byte_q;
        data_hold_d  = data_hold_q;
        pairs_sent_d = pairs_sent_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_c)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end

        // flush only touches the queue; an in-flight pair always completes.
        case (state_q)
            ST_IDLE: begin
                if (pop_c) begin
                    state_d     = ST_SEND_CMD;
                    ser_load_d  = 1'b1;
                    ser_byte_d  = mem_q[rd_ptr_q].code;
                    data_hold_d = mem_q[rd_ptr_q].data;
                end
            end
            ST_SEND_CMD: begin
                if (ser_done) begin
                    state_d    = ST_SEND_DATA;
                    ser_load_d = 1'b1;
                    ser_byte_d = data_hold_q;
                end
            end
            ST_SEND_DATA: begin
                if (ser_done) begin
                    state_d      = ST_IDLE;
                    pairs_sent_d = pairs_sent_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (count_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            ser_load_q   <= 1'b0;
            ser_byte_q   <= '0;
            data_hold_q  <= '0;
            pairs_sent_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            ser_load_q   <= ser_load_d;
            ser_byte_q   <= ser_byte_d;
            data_hold_q  <= data_hold_d;
            pairs_sent_q <= pairs_sent_d;
            busy_q       <= busy_d;
        end
    end

    // Pair storage needs no reset; count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= '{code: cmd_code, data: cmd_data};
    end

    iosys_uart_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .GAP_BITS     (GAP_BITS)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ser_load_q),
        .tx_byte (ser_byte_q),
        .tx      (uart_tx),
        .done    (ser_done)
    );

    assign busy       = busy_q;
    assign pairs_sent = pairs_sent_q;

endmodule
